// File: rtl/cp0_regs.sv
// Coprocessor-0 register file: BadVAddr, Count, Compare, Status, Cause, EPC,
// exception/eret bookkeeping and the Count/Compare timer interrupt.
module cp0_regs #(
  parameter int TICK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  output logic [31:0] epc_out,
  output logic        exl_out,
  output logic        int_req
);

  logic [31:0] r_badvaddr, r_count, r_compare, r_epc;
  logic [7:0]  r_im;
  logic        r_exl, r_ie, r_bd, r_ti, r_phase;
  logic [5:0]  r_ip_hw;
  logic [1:0]  r_ip_sw;
  logic [4:0]  r_exccode;

  logic        w_wr_en, w_wr_count, w_wr_compare, w_tick, w_ti_nxt;
  logic [31:0] w_status, w_cause;

  // mtc0 loses to exception entry and eret in the same cycle
  assign w_wr_en      = we & ~exc_valid & ~eret;
  assign w_wr_count   = w_wr_en & (waddr == 5'd9);
  assign w_wr_compare = w_wr_en & (waddr == 5'd11);
  assign w_tick       = (TICK_DIV == 1) | r_phase;

  // Compare write beats a coincident Count==Compare match
  assign w_ti_nxt = w_wr_compare ? 1'b0 :
                    (r_count == r_compare) ? 1'b1 : r_ti;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count   <= '0;
      r_phase   <= 1'b0;
      r_compare <= '0;
      r_ti      <= 1'b0;
      r_ip_hw   <= '0;
    end else begin
      r_ti    <= w_ti_nxt;
      r_ip_hw <= {hw_int[5] | w_ti_nxt, hw_int[4:0]};
      if (w_wr_count) begin
        r_count <= wdata;
        r_phase <= 1'b0;
      end else begin
        if (w_tick) r_count <= r_count + 32'd1;
        if (TICK_DIV == 2) r_phase <= ~r_phase;
      end
      if (w_wr_compare) r_compare <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_badvaddr <= '0;
      r_epc      <= '0;
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip_sw    <= '0;
      r_exccode  <= '0;
    end else if (exc_valid) begin
      r_exccode <= exc_code;
      r_exl     <= 1'b1;
      // nested exceptions keep the outermost return point
      if (!r_exl) begin
        r_epc <= exc_bd ? exc_pc - 32'd4 : exc_pc;
        r_bd  <= exc_bd;
      end
      if (exc_code == 5'd4 || exc_code == 5'd5) r_badvaddr <= exc_badvaddr;
    end else if (eret) begin
      r_exl <= 1'b0;
    end else if (we) begin
      case (waddr)
        5'd12: begin
          r_im  <= wdata[15:8];
          r_exl <= wdata[1];
          r_ie  <= wdata[0];
        end
        5'd13:   r_ip_sw <= wdata[9:8];
        5'd14:   r_epc   <= wdata;
        default: ;
      endcase
    end
  end

  assign w_status = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
  assign w_cause  = {r_bd, r_ti, 14'b0, r_ip_hw, r_ip_sw, 1'b0, r_exccode, 2'b0};

  always_comb begin
    rdata = '0;
    case (raddr)
      5'd8:    rdata = r_badvaddr;
      5'd9:    rdata = r_count;
      5'd11:   rdata = r_compare;
      5'd12:   rdata = w_status;
      5'd13:   rdata = w_cause;
      5'd14:   rdata = r_epc;
      default: rdata = '0;
    endcase
  end

  assign epc_out = r_epc;
  assign exl_out = r_exl;
  assign int_req = r_ie & ~r_exl & (|({r_ip_hw, r_ip_sw} & r_im));

endmodule
